// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port among N_REQ writeback requesters
//   using round-robin arbitration. It can also run a "sweep" that writes SWEEP_VAL
//   to x1..x31, one register per cycle, so the register file can be cleared without
//   a global reset. The outputs drive the Regs block directly.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester pending write
//   req_addr     packed destinations, requester i in [i*ADDR_W +: ADDR_W]
//   req_data     packed write data, requester i in [i*DATA_W +: DATA_W]
//   req_ready    one-hot combinational grant; a transfer is valid & ready
//   sweep_start  pulse that starts clearing x1..x31
//   busy         high while a sweep is in progress
//   sweep_done   one-cycle pulse issued together with the x31 sweep write
//   RegWrite     registered write enable to the register file
//   Wt_addr      registered write address
//   Wt_data      registered write data
//   grant_id     registered index of the requester whose write is on Wt_*

module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] SWEEP_VAL = '0,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     sweep_start,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        Wt_addr,
  output logic [DATA_W-1:0]        Wt_data,
  output logic [IDX_W-1:0]         grant_id
);

  typedef enum logic {ARB, SWEEP} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(31);

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [ADDR_W-1:0]  cnt;

  logic               found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               arb_open;
  logic               xfer;
  int                 cand;

  // Arbitration is only open in ARB and only when no sweep is being requested,
  // since a sweep request takes priority over all writeback traffic.
  assign arb_open = (state == ARB) && !sweep_start;
  assign busy     = (state == SWEEP);
  assign xfer     = |(req_valid & req_ready);

  // Round-robin search: walk the requesters starting just after last_grant and
  // wrapping, taking the first valid one. The inner loop keeps every index a
  // loop constant so no variable-width bit selects are needed.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == cand) && req_valid[j]) begin
          found   = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (found && (gnt_idx == IDX_W'(j))) begin
        sel_addr = req_addr[j*ADDR_W +: ADDR_W];
        sel_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot ready on the winning requester, suppressed while arbitration is closed.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < N_REQ; j++) begin
      req_ready[j] = arb_open && found && (gnt_idx == IDX_W'(j));
    end
  end

  // FSM with registered write-port outputs. A transfer to x0 is accepted and
  // moves the round-robin pointer, but the write enable is held low so x0 is
  // never written. During a sweep the counter drives the address directly, and
  // the edge that loads x31 both raises sweep_done and returns to ARB so that
  // arbitration resumes in the same cycle the last sweep write is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      last_grant <= IDX_W'(N_REQ - 1);
      cnt        <= '0;
      RegWrite   <= 1'b0;
      Wt_addr    <= '0;
      Wt_data    <= '0;
      grant_id   <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        ARB: begin
          if (sweep_start) begin
            state    <= SWEEP;
            cnt      <= ADDR_W'(1);
            RegWrite <= 1'b0;
          end else if (xfer) begin
            last_grant <= gnt_idx;
            RegWrite   <= (sel_addr != '0);
            Wt_addr    <= sel_addr;
            Wt_data    <= sel_data;
            grant_id   <= gnt_idx;
          end else begin
            RegWrite <= 1'b0;
          end
        end
        SWEEP: begin
          RegWrite <= 1'b1;
          Wt_addr  <= cnt;
          Wt_data  <= SWEEP_VAL;
          grant_id <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_REG) begin
            state      <= ARB;
            sweep_done <= 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed self-checking bench for regfile_wb_arbiter (N_REQ=3, ADDR_W=5,
//   DATA_W=32, SWEEP_VAL=0). Inputs change just after the falling edge; a cycle
//   "T" is the span between two rising edges, so after the falling edge inside
//   cycle T the combinational ready reflects cycle T and the registered outputs
//   reflect the transfer of cycle T-1.

module tb_regfile_wb_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    sweep_start;
  logic                    busy;
  logic                    sweep_done;
  logic                    RegWrite;
  logic [ADDR_W-1:0]       Wt_addr;
  logic [DATA_W-1:0]       Wt_data;
  logic [IDX_W-1:0]        grant_id;

  int vectors;
  int miscompares;

  regfile_wb_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SWEEP_VAL(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .sweep_start(sweep_start),
    .busy(busy), .sweep_done(sweep_done),
    .RegWrite(RegWrite), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loads one requester slot with address and data.
  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Reset state of every output, checked while reset is asserted.
  task automatic test_reset;
    req_valid = '0; req_addr = '0; req_data = '0; sweep_start = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({RegWrite, Wt_addr, Wt_data, grant_id, busy, sweep_done, req_ready} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got RegWrite=%b addr=%0d data=%h gid=%0d busy=%b done=%b ready=%b, want all 0",
               RegWrite, Wt_addr, Wt_data, grant_id, busy, sweep_done, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // All three requesters valid: grants rotate 0,1,2,0,1,2 with one-cycle write latency.
  task automatic test_round_robin;
    logic [ADDR_W-1:0] ea [3];
    logic [DATA_W-1:0] ed [3];
    logic [N_REQ-1:0]  er;
    int p;
    ea = '{5'd3, 5'd4, 5'd6};
    ed = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222};
    for (int i = 0; i < 3; i++) set_req(i, ea[i], ed[i]);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = (c < 6) ? 3'b111 : 3'b000;
      #1;
      if (c < 6) begin
        er = 3'b001 << (c % 3);
        vectors++;
        if (req_ready !== er) begin
          miscompares++;
          $display("[TB] FAIL rr_ready c%0d: got %b want %b", c, req_ready, er);
        end
      end
      if (c > 0) begin
        p = (c - 1) % 3;
        vectors++;
        if (RegWrite !== 1'b1 || Wt_addr !== ea[p] || Wt_data !== ed[p] || grant_id !== IDX_W'(p)) begin
          miscompares++;
          $display("[TB] FAIL rr_write c%0d: got we=%b addr=%0d data=%h gid=%0d want we=1 addr=%0d data=%h gid=%0d",
                   c, RegWrite, Wt_addr, Wt_data, grant_id, ea[p], ed[p], p);
        end
      end else begin
        vectors++;
        if (RegWrite !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rr_first_idle: got RegWrite=%b want 0", RegWrite);
        end
      end
    end
  endtask

  // Single requester 2 write; then an idle cycle where Wt_addr/Wt_data must hold.
  task automatic test_single;
    set_req(2, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    vectors++;
    if (req_ready !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b want 100", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    vectors++;
    if (RegWrite !== 1'b1 || Wt_addr !== 5'd5 || Wt_data !== 32'hDEAD_BEEF || grant_id !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL single_write: got we=%b addr=%0d data=%h gid=%0d want we=1 addr=5 data=deadbeef gid=2",
               RegWrite, Wt_addr, Wt_data, grant_id);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (RegWrite !== 1'b0 || Wt_addr !== 5'd5 || Wt_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL idle_hold: got we=%b addr=%0d data=%h want we=0 addr=5 data=deadbeef",
               RegWrite, Wt_addr, Wt_data);
    end
  endtask

  // Write to x0 is accepted but suppressed; the pointer still moves to 1 so 2 wins the next tie.
  task automatic test_addr_zero;
    set_req(0, 5'd10, 32'h0000_0A0A);
    set_req(1, 5'd0,  32'h0000_1234);
    set_req(2, 5'd12, 32'h0000_0C0C);
    @(negedge clk);
    req_valid = 3'b010;
    #1;
    vectors++;
    if (req_ready !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL x0_ready: got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b111;
    #1;
    vectors++;
    if (RegWrite !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL x0_no_write: got RegWrite=%b want 0", RegWrite);
    end
    vectors++;
    if (req_ready !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL x0_next_tie: got %b want 100", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    vectors++;
    if (RegWrite !== 1'b1 || Wt_addr !== 5'd12 || grant_id !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL x0_tie_write: got we=%b addr=%0d gid=%0d want we=1 addr=12 gid=2",
               RegWrite, Wt_addr, grant_id);
    end
  endtask

  // Full sweep started at T; optional second start pulse at T+restart_at (0 = none).
  // When with_req is set, requester 0 stays valid and must be served at T+32.
  task automatic test_sweep(input bit with_req, input int restart_at);
    int writes;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    writes = 0;
    set_req(0, 5'd9, 32'hCAFE_0000);
    @(negedge clk);
    sweep_start = 1'b1;
    req_valid   = with_req ? 3'b001 : 3'b000;
    #1;
    vectors++;
    if (req_ready !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sweep_T: got ready=%b busy=%b want ready=000 busy=0", req_ready, busy);
    end
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      sweep_start = (restart_at != 0 && c == restart_at);
      if (c == 33) req_valid = 3'b000;
      #1;
      if (c <= 32) begin
        vectors++;
        if (req_ready !== ((c == 32 && with_req) ? 3'b001 : 3'b000)) begin
          miscompares++;
          $display("[TB] FAIL sweep_ready T+%0d: got %b", c, req_ready);
        end
      end
      vectors++;
      if (busy !== (c <= 31) || sweep_done !== (c == 32)) begin
        miscompares++;
        $display("[TB] FAIL sweep_flags T+%0d: got busy=%b done=%b want busy=%b done=%b",
                 c, busy, sweep_done, (c <= 31), (c == 32));
      end
      if (c >= 2 && c <= 32) begin
        exp_we = 1'b1; exp_addr = ADDR_W'(c - 1); exp_data = 32'h0;
      end else if (c == 33 && with_req) begin
        exp_we = 1'b1; exp_addr = 5'd9; exp_data = 32'hCAFE_0000;
      end else begin
        exp_we = 1'b0; exp_addr = Wt_addr; exp_data = Wt_data;
      end
      if (c <= 32 && RegWrite === 1'b1) writes++;
      vectors++;
      if (RegWrite !== exp_we || (exp_we && (Wt_addr !== exp_addr || Wt_data !== exp_data || grant_id !== 2'd0))) begin
        miscompares++;
        $display("[TB] FAIL sweep_write T+%0d: got we=%b addr=%0d data=%h gid=%0d want we=%b addr=%0d data=%h gid=0",
                 c, RegWrite, Wt_addr, Wt_data, grant_id, exp_we, exp_addr, exp_data);
      end
    end
    vectors++;
    if (writes != 31) begin
      miscompares++;
      $display("[TB] FAIL sweep_count: got %0d writes want 31", writes);
    end
  endtask

  // Reset asserted at T+15 of a sweep: outputs clear at once and the sweep does not resume.
  task automatic test_reset_mid_sweep;
    @(negedge clk);
    sweep_start = 1'b1;
    req_valid   = 3'b000;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      sweep_start = 1'b0;
    end
    #1;
    vectors++;
    if (busy !== 1'b1 || RegWrite !== 1'b1 || Wt_addr !== 5'd14) begin
      miscompares++;
      $display("[TB] FAIL pre_abort: got busy=%b we=%b addr=%0d want busy=1 we=1 addr=14", busy, RegWrite, Wt_addr);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({RegWrite, Wt_addr, Wt_data, grant_id, busy, sweep_done} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_abort: got we=%b addr=%0d data=%h gid=%0d busy=%b done=%b want all 0",
               RegWrite, Wt_addr, Wt_data, grant_id, busy, sweep_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (RegWrite !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_abort c%0d: got we=%b busy=%b done=%b want 0", c, RegWrite, busy, sweep_done);
      end
    end
    set_req(0, 5'd7, 32'h0000_7777);
    set_req(1, 5'd8, 32'h0000_8888);
    @(negedge clk);
    req_valid = 3'b011;
    #1;
    vectors++;
    if (req_ready !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL post_abort_ready: got %b want 001", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    vectors++;
    if (RegWrite !== 1'b1 || Wt_addr !== 5'd7 || Wt_data !== 32'h0000_7777 || grant_id !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL post_abort_write: got we=%b addr=%0d data=%h gid=%0d want we=1 addr=7 data=7777 gid=0",
               RegWrite, Wt_addr, Wt_data, grant_id);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_addr_zero();
    test_sweep(1'b1, 0);
    test_sweep(1'b0, 10);
    test_reset_mid_sweep();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
